// File: rtl/mux_scan_controller.sv
// Scans an external 16x1 mux over the enabled channels in ascending order,
// holding sel for SETTLE_CYCLES before each sample, and publishes the result vector.
module mux_scan_controller #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cont,
    input  logic [15:0] mask,
    input  logic        mux_out,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] capture
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_t;

    localparam logic [3:0] C_SETTLE = 4'(SETTLE_CYCLES);

    state_t      r_state;
    logic [15:0] r_mask;
    logic [15:0] r_buf;
    logic [3:0]  r_cnt;
    logic [3:0]  r_sel;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_capture;

    logic [15:0] w_above;
    logic [15:0] w_buf_sampled;
    logic [3:0]  w_first_idx;
    logic [3:0]  w_next_idx;
    logic        w_next_any;
    logic        w_launch;

    // Lowest set bit; callers only use the result when the vector is nonzero.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bits
            assign w_above[gi]       = r_mask[gi] & (r_sel < 4'(gi));
            assign w_buf_sampled[gi] = (r_sel == 4'(gi)) ? mux_out : r_buf[gi];
        end
    endgenerate

    assign w_first_idx = lowest_set(mask);
    assign w_next_idx  = lowest_set(w_above);
    assign w_next_any  = |w_above;

    // A continuous-mode FINISH relaunches exactly like a start request in IDLE.
    assign w_launch = ((r_state == ST_IDLE) && start) || ((r_state == ST_FINISH) && cont);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_mask    <= 16'h0000;
            r_buf     <= 16'h0000;
            r_cnt     <= 4'd0;
            r_sel     <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_capture <= 16'h0000;
        end else if (w_launch) begin
            r_mask <= mask;
            r_buf  <= 16'h0000;
            r_busy <= 1'b1;
            if (mask != 16'h0000) begin
                r_sel   <= w_first_idx;
                r_cnt   <= C_SETTLE;
                r_state <= ST_SETTLE;
                r_done  <= 1'b0;
            end else begin
                r_sel     <= 4'd0;
                r_capture <= 16'h0000;
                r_state   <= ST_FINISH;
                r_done    <= 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sel  <= 4'd0;
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
                ST_SETTLE: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_buf <= w_buf_sampled;
                    if (w_next_any) begin
                        r_sel   <= w_next_idx;
                        r_cnt   <= C_SETTLE;
                        r_state <= ST_SETTLE;
                    end else begin
                        // Final sample goes straight into capture on the same edge.
                        r_capture <= w_buf_sampled;
                        r_sel     <= 4'd0;
                        r_state   <= ST_FINISH;
                        r_done    <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign sel     = r_sel;
    assign busy    = r_busy;
    assign done    = r_done;
    assign capture = r_capture;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Randomized self-checking bench: a mux model feeds in_vec[sel] back, and each
// scan is checked against timing/ordering derived from the mask and SETTLE_CYCLES.
module tb_mux_scan_controller;

    localparam int S = 1;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cont;
    logic [15:0] mask;
    logic        mux_out;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic [15:0] capture;

    logic [15:0] in_vec;
    logic [15:0] exp_cap;
    int          total;
    int          bad;

    mux_scan_controller #(.SETTLE_CYCLES(S)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .cont    (cont),
        .mask    (mask),
        .mux_out (mux_out),
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .capture (capture)
    );

    assign mux_out = in_vec[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // k-th enabled channel (0-based) in ascending index order.
    function automatic logic [31:0] nth_set(input logic [15:0] m, input int k);
        int seen;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                if (seen == k) return 32'(i);
                seen++;
            end
        end
        return 32'hFFFF_FFFF;
    endfunction

    // One single-shot scan; with chaos, mask and start toggle randomly while busy.
    task automatic scan_check(input logic [15:0] m, input logic [15:0] inv, input bit chaos);
        int lat;
        lat = $countones(m) * (S + 1);
        @(negedge clk);
        mask   = m;
        in_vec = inv;
        start  = 1'b1;
        cont   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) @(negedge clk);
            check("done", 32'(done), 32'(c == lat));
            check("busy", 32'(busy), 32'd1);
            if (c < lat) begin
                check("sel", 32'(sel), nth_set(m, c / (S + 1)));
                check("cap_hold", 32'(capture), 32'(exp_cap));
            end else begin
                exp_cap = inv & m;
                check("capture", 32'(capture), 32'(exp_cap));
            end
            if (chaos && c < lat) begin
                mask  = 16'($urandom);
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_sel", 32'(sel), 32'd0);
        check("idle_cap", 32'(capture), 32'(exp_cap));
        $display("scan mask=%04h in=%04h latency=%0d capture=%04h", m, inv, lat, capture);
    endtask

    initial begin
        bit hit;
        total   = 0;
        bad     = 0;
        exp_cap = 16'h0000;
        rst_n   = 1'b0;
        start   = 1'b0;
        cont    = 1'b0;
        mask    = 16'h0000;
        in_vec  = 16'h0000;

        #3;
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cap", 32'(capture), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        scan_check(16'hFFFF, 16'hA5C3, 1'b0);
        scan_check(16'h8001, 16'hFFFF, 1'b0);
        scan_check(16'h0000, 16'hFFFF, 1'b0);

        for (int t = 0; t < 8; t++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (t % 2 == 1) m = m & 16'($urandom) & 16'($urandom);
            scan_check(m, 16'($urandom), 1'b1);
        end

        // Continuous mode: mask change and start pulse during scan 1 have no effect.
        @(negedge clk);
        in_vec = 16'($urandom) | 16'h00FF;
        mask   = 16'h000F;
        cont   = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= 18; c++) begin
            if (c > 0) @(negedge clk);
            check("cont_done", 32'(done), 32'((c == 8) || (c == 17)));
            check("cont_busy", 32'(busy), 32'(c < 18));
            if (c < 8) check("cont_sel1", 32'(sel), nth_set(16'h000F, c / (S + 1)));
            if (c > 8 && c < 17) check("cont_sel2", 32'(sel), nth_set(16'h00F0, (c - 9) / (S + 1)));
            if (c == 8) check("cont_cap1", 32'(capture), 32'(in_vec & 16'h000F));
            if (c == 17) check("cont_cap2", 32'(capture), 32'(in_vec & 16'h00F0));
            start = (c == 1) || (c == 12);
            if (c == 1) mask = 16'h00F0;
            if (c == 9) cont = 1'b0;
        end
        exp_cap = in_vec & 16'h00F0;
        $display("continuous scans mask=000F then 00F0 capture=%04h", capture);

        // Asynchronous reset between edges with a nonzero capture held.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_cap", 32'(capture), 32'd0);
        exp_cap = 16'h0000;
        @(posedge clk);
        #2 rst_n = 1'b1;
        $display("async reset between edges");

        // Mid-scan reset while sel=5 aborts without a done pulse.
        @(negedge clk);
        mask   = 16'hFFFF;
        in_vec = 16'($urandom);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (sel == 4'd5) hit = 1'b1;
            else @(negedge clk);
        end
        check("reach_sel5", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_sel", 32'(sel), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_cap", 32'(capture), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mrst_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        $display("reset mid-scan at sel=5");
        scan_check(16'hF0F0, 16'($urandom), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
